bin_to_trit_serializer: RTL and testbench
=========================================

BIN_TO_TRIT_SERIALIZER -- requirements
Module: bin_to_trit_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning binary input word width.
REQ-002 The block SHALL have parameter NTRITS, default 6, meaning trits emitted per word; legal only when 3^NTRITS >= 2^WIDTH.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_data, input, WIDTH, unsigned binary word to convert.
REQ-006 The block SHALL have port in_valid, input, 1, in_data is valid.
REQ-007 The block SHALL have port in_ready, output, 1, block can accept a word.
REQ-008 The block SHALL have port out_trit, output, 2, the current trit in two-wire ternary code.
REQ-009 The block SHALL have port out_valid, output, 1, out_trit is valid.
REQ-010 The block SHALL have port out_ready, input, 1, the downstream ternary stage accepts out_trit.
REQ-011 The block SHALL have port out_last, output, 1, out_trit is the most significant trit of the word.
REQ-012 The block SHALL have port par_word, output, 2*NTRITS, full encoded result; trit k at bits [2k+1:2k].
REQ-013 The block SHALL have port par_valid, output, 1, one-cycle pulse when par_word updates.

Function
REQ-014 Trit encoding SHALL be: value 0 -> 2'b01, value 1 -> 2'b11, value 2 -> 2'b10; 2'b00 SHALL never be driven on out_trit or in par_word after reset.
REQ-015 The FSM SHALL have two states: IDLE and EMIT.
REQ-016 In IDLE, in_ready SHALL be 1 and out_valid 0; on in_valid && in_ready, the word SHALL be loaded into a WIDTH-bit remainder register, trit counter cleared to 0, state -> EMIT.
REQ-017 In EMIT, in_ready SHALL be 0, out_valid 1, out_trit = encode(remainder mod 3), out_last = (counter == NTRITS-1).
REQ-018 First trit SHALL be valid the cycle after input acceptance (latency 1); trits SHALL be emitted least significant first.
REQ-019 On out_valid && out_ready, remainder SHALL become floor(remainder/3) and counter increment; mod-3 and div-3 SHALL be combinational from the remainder register.
REQ-020 While out_ready is 0 in EMIT, out_trit, out_last, remainder and counter SHALL hold unchanged.
REQ-021 Handshake on the out_last trit SHALL return state to IDLE the next cycle; a new word SHALL not be accepted in that same cycle (one idle bubble per word, NTRITS+1 cycles minimum per word).
REQ-022 Each accepted trit SHALL be written into an internal shadow of par_word at position counter; on the out_last handshake, par_word SHALL update from the shadow plus final trit and par_valid pulse 1 for exactly the next cycle.
REQ-023 par_word SHALL hold its value between words; in_valid while not in IDLE SHALL be ignored (no loss, upstream holds).
REQ-024 Leading-zero trits SHALL still be emitted (always exactly NTRITS trits per word).

Reset
REQ-025 On rst_n low, asynchronously: state IDLE, counter 0, remainder 0, out_valid 0, out_last 0, par_valid 0, out_trit 2'b01, par_word all trits 2'b01, in_ready 1 on first cycle after release.
REQ-026 Reset asserted mid-EMIT SHALL abort the word: no par_valid pulse, no further trits, partial shadow discarded.

Verification
REQ-027 in_data=0, out_ready=1 -> six trits 01 each, out_last on 6th only, par_word=12'h555, par_valid one cycle.
REQ-028 in_data=255 (base 3 100110), out_ready=1 -> trit values LSB-first 0,1,1,0,0,1 = codes 01,11,11,01,01,11; par_word=12'b11_01_01_11_11_01.
REQ-029 in_data=5 with out_ready toggling 1/0 each cycle -> values 2,1,0,0,0,0 (codes 10,11,01,01,01,01), outputs stable during stalls, 11 cycles accept-to-last.
REQ-030 Back-to-back words 5 then 0 with in_valid held high -> second word accepted exactly one IDLE cycle after first out_last handshake, trits not interleaved.
REQ-031 Reset pulse after 3rd trit of 255 -> out_valid 0 immediately, par_word 12'h555, par_valid never pulses, next word converts correctly.
REQ-032 Every cycle after reset: out_trit != 2'b00 and out_valid implies counter < NTRITS.

Source files
------------

// File: rtl/bin_to_trit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_trit_serializer
//  Description : Converts an unsigned WIDTH-bit binary word into NTRITS
//                balanced-wire ternary digits, streamed least significant
//                trit first over a valid/ready link, and also presents the
//                complete encoded word in parallel once the last trit leaves.
//                Trit codes: 0 -> 2'b01, 1 -> 2'b11, 2 -> 2'b10.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_trit_serializer #(
    parameter int WIDTH  = 8,
    parameter int NTRITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [1:0]            out_trit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [2*NTRITS-1:0]   par_word,
    output logic                  par_valid
);

    // Counter only ever holds 0..NTRITS-1; it is cleared on the final trit.
    localparam int CNT_W = (NTRITS > 1) ? $clog2(NTRITS) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    localparam logic [1:0]          c_TRIT_ZERO = 2'b01;
    localparam logic [2*NTRITS-1:0] c_PAR_RESET = {NTRITS{2'b01}};
    localparam logic [CNT_W-1:0]    c_LAST_CNT  = CNT_W'(NTRITS - 1);

    // Map a digit value 0..2 onto its two-wire code; 2'b00 is never produced.
    function automatic logic [1:0] f_encode(input logic [1:0] v);
        case (v)
            2'd0:    f_encode = 2'b01;
            2'd1:    f_encode = 2'b11;
            default: f_encode = 2'b10;
        endcase
    endfunction

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [WIDTH-1:0]    r_rem;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_shadow [NTRITS];
    logic [2*NTRITS-1:0] r_par_word;
    logic                r_par_valid;

    logic [1:0]          w_mod3;
    logic [WIDTH-1:0]    w_div3;
    logic [1:0]          w_trit;
    logic                w_load;
    logic                w_take;
    logic                w_last_take;
    logic [2*NTRITS-1:0] w_par_next;

    // Digit extraction is purely combinational from the remainder register.
    assign w_mod3 = 2'(r_rem % WIDTH'(3));
    assign w_div3 = r_rem / WIDTH'(3);
    assign w_trit = f_encode(w_mod3);

    assign w_load      = (r_state == S_IDLE) && in_valid;
    assign w_take      = (r_state == S_EMIT) && out_ready;
    assign w_last_take = w_take && (r_cnt == c_LAST_CNT);

    // Parallel result: earlier trits from the shadow, the top trit straight
    // from the digit currently being handed off.
    for (genvar k = 0; k < NTRITS; k++) begin : g_pack
        if (k == NTRITS - 1) begin : g_final
            assign w_par_next[2*k +: 2] = w_trit;
        end else begin : g_mid
            assign w_par_next[2*k +: 2] = r_shadow[k];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: load a word in IDLE, leave EMIT on the last handshake.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_load)      w_state_next = S_EMIT;
            S_EMIT:  if (w_last_take) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output decode from state and datapath registers.
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_EMIT);
        out_last  = (r_state == S_EMIT) && (r_cnt == c_LAST_CNT);
        out_trit  = w_trit;
    end

    // Datapath: remainder, trit counter, shadow and parallel result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem       <= '0;
            r_cnt       <= '0;
            r_par_word  <= c_PAR_RESET;
            r_par_valid <= 1'b0;
            for (int k = 0; k < NTRITS; k++) begin
                r_shadow[k] <= c_TRIT_ZERO;
            end
        end else begin
            r_par_valid <= 1'b0;
            if (w_load) begin
                r_rem <= in_data;
                r_cnt <= '0;
            end else if (w_take) begin
                r_rem           <= w_div3;
                r_shadow[r_cnt] <= w_trit;
                if (w_last_take) begin
                    r_cnt       <= '0;
                    r_par_word  <= w_par_next;
                    r_par_valid <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign par_word  = r_par_word;
    assign par_valid = r_par_valid;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_trit_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_bin_to_trit_serializer
//  Description : Self-checking bench for bin_to_trit_serializer; expected
//                trits come from repeated integer division by three.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_trit_serializer;

    localparam int WIDTH  = 8;
    localparam int NTRITS = 6;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [WIDTH-1:0]    in_data;
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          out_trit;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic [2*NTRITS-1:0] par_word;
    logic                par_valid;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 0;

    logic [1:0] got_code [$];
    logic       got_last [$];
    int         last_cyc;
    bit         done;
    int         stall_bad;
    int         pv_early;
    int         ready_bad;

    bin_to_trit_serializer #(.WIDTH(WIDTH), .NTRITS(NTRITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_trit  (out_trit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .par_word  (par_word),
        .par_valid (par_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] enc(input int v);
        case (v)
            0:       return 2'b01;
            1:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [1:0] model_trit(input int v, input int k);
        int x = v;
        for (int i = 0; i < k; i++) x = x / 3;
        return enc(x % 3);
    endfunction

    function automatic logic [2*NTRITS-1:0] model_word(input int v);
        logic [2*NTRITS-1:0] r = '0;
        for (int k = 0; k < NTRITS; k++) r[2*k +: 2] = model_trit(v, k);
        return r;
    endfunction

    // The two-wire code 2'b00 must never appear once out of reset.
    always @(negedge clk) begin
        if (mon_en && rst_n === 1'b1) begin
            n_tests++;
            if (out_trit === 2'b00 || $isunknown(out_trit)) begin
                n_fail++;
                $display("FAIL monitor out_trit: got %b required non-00", out_trit);
            end
        end
    end

    // Offer one word and collect trits until the last handshake (bounded).
    // mode 0: out_ready held high; mode 1: out_ready high on odd cycles only.
    task automatic run_word(input logic [WIDTH-1:0] d, input int mode);
        bit         have_stall;
        logic [1:0] st_trit;
        logic       st_last;
        got_code.delete();
        got_last.delete();
        last_cyc   = -1;
        done       = 0;
        stall_bad  = 0;
        pv_early   = 0;
        ready_bad  = 0;
        have_stall = 0;
        in_data    = d;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 1);
            if (have_stall && (out_trit !== st_trit || out_last !== st_last)) stall_bad++;
            have_stall = 0;
            if (in_ready !== 1'b0) ready_bad++;
            if (par_valid !== 1'b0) pv_early++;
            if (out_valid === 1'b1 && out_ready) begin
                got_code.push_back(out_trit);
                got_last.push_back(out_last);
                if (out_last === 1'b1) begin
                    done     = 1;
                    last_cyc = cyc;
                end
            end else if (out_valid === 1'b1) begin
                have_stall = 1;
                st_trit    = out_trit;
                st_last    = out_last;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b required 0", out_valid); end
        n_tests++;
        if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset out_last: got %b required 0", out_last); end
        n_tests++;
        if (par_valid !== 1'b0) begin n_fail++; $display("FAIL reset par_valid: got %b required 0", par_valid); end
        n_tests++;
        if (out_trit !== 2'b01) begin n_fail++; $display("FAIL reset out_trit: got %b required 01", out_trit); end
        n_tests++;
        if (par_word !== 12'h555) begin n_fail++; $display("FAIL reset par_word: got %h required 555", par_word); end
        rst_n  = 1'b1;
        mon_en = 1;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b required 1", in_ready); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle out_valid: got %b required 0", out_valid); end
    endtask

    task automatic test_word(input string name, input logic [WIDTH-1:0] d, input int mode);
        logic [2*NTRITS-1:0] exp_word;
        exp_word = model_word(int'(d));
        run_word(d, mode);
        n_tests++;
        if (!done) begin n_fail++; $display("FAIL %s timeout: got no out_last required one within 60 cycles", name); end
        n_tests++;
        if (got_code.size() != NTRITS) begin
            n_fail++; $display("FAIL %s trit_count: got %0d required %0d", name, got_code.size(), NTRITS);
        end
        for (int k = 0; k < got_code.size() && k < NTRITS; k++) begin
            n_tests++;
            if (got_code[k] !== model_trit(int'(d), k)) begin
                n_fail++; $display("FAIL %s trit%0d (data %0d): got %b required %b", name, k, d, got_code[k], model_trit(int'(d), k));
            end
            n_tests++;
            if (got_last[k] !== (k == NTRITS - 1)) begin
                n_fail++; $display("FAIL %s last%0d: got %b required %b", name, k, got_last[k], (k == NTRITS - 1));
            end
        end
        n_tests++;
        if (last_cyc != ((mode == 0) ? NTRITS : 2*NTRITS - 1)) begin
            n_fail++; $display("FAIL %s latency: got %0d required %0d", name, last_cyc, (mode == 0) ? NTRITS : 2*NTRITS - 1);
        end
        if (mode != 0) begin
            n_tests++;
            if (stall_bad != 0) begin n_fail++; $display("FAIL %s stall_hold: got %0d changes required 0", name, stall_bad); end
        end
        n_tests++;
        if (ready_bad != 0) begin n_fail++; $display("FAIL %s in_ready_busy: got %0d high cycles required 0", name, ready_bad); end
        n_tests++;
        if (pv_early != 0) begin n_fail++; $display("FAIL %s par_valid_early: got %0d cycles required 0", name, pv_early); end
        n_tests++;
        if (par_valid !== 1'b1) begin n_fail++; $display("FAIL %s par_valid: got %b required 1", name, par_valid); end
        n_tests++;
        if (par_word !== exp_word) begin n_fail++; $display("FAIL %s par_word: got %b required %b", name, par_word, exp_word); end
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s return_idle: got in_ready=%b out_valid=%b required 1/0", name, in_ready, out_valid);
        end
        @(posedge clk); #1;
        n_tests++;
        if (par_valid !== 1'b0) begin n_fail++; $display("FAIL %s par_valid_pulse: got %b required 0", name, par_valid); end
        n_tests++;
        if (par_word !== exp_word) begin n_fail++; $display("FAIL %s par_word_hold: got %b required %b", name, par_word, exp_word); end
    endtask

    task automatic test_back_to_back();
        in_data   = 8'd5;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_data = 8'd0;
        for (int k = 0; k < NTRITS; k++) begin
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_trit !== model_trit(5, k)) begin
                n_fail++; $display("FAIL b2b first trit%0d: got v=%b r=%b t=%b required v=1 r=0 t=%b", k, out_valid, in_ready, out_trit, model_trit(5, k));
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b bubble: got in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        n_tests++;
        if (par_valid !== 1'b1 || par_word !== model_word(5)) begin
            n_fail++; $display("FAIL b2b first par: got pv=%b word=%h required pv=1 word=%h", par_valid, par_word, model_word(5));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < NTRITS; k++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_trit !== model_trit(0, k) || out_last !== (k == NTRITS - 1)) begin
                n_fail++; $display("FAIL b2b second trit%0d: got v=%b t=%b l=%b required v=1 t=%b l=%b", k, out_valid, out_trit, out_last, model_trit(0, k), (k == NTRITS - 1));
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (par_valid !== 1'b1 || par_word !== 12'h555) begin
            n_fail++; $display("FAIL b2b second par: got pv=%b word=%h required pv=1 word=555", par_valid, par_word);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int pv_seen = 0;
        int ov_seen = 0;
        in_data   = 8'd255;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset out_valid: got %b required 0", out_valid); end
        n_tests++;
        if (par_word !== 12'h555) begin n_fail++; $display("FAIL midreset par_word: got %h required 555", par_word); end
        n_tests++;
        if (par_valid !== 1'b0) begin n_fail++; $display("FAIL midreset par_valid: got %b required 0", par_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (par_valid !== 1'b0) pv_seen++;
            if (out_valid !== 1'b0) ov_seen++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (pv_seen != 0) begin n_fail++; $display("FAIL midreset par_valid_after: got %0d pulses required 0", pv_seen); end
        n_tests++;
        if (ov_seen != 0) begin n_fail++; $display("FAIL midreset out_valid_after: got %0d cycles required 0", ov_seen); end
        test_word("after_reset", 8'd255, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            test_word("random", WIDTH'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_word("zero", 8'd0, 0);
        test_word("max", 8'd255, 0);
        test_word("stall5", 8'd5, 1);
        test_word("one", 8'd1, 1);
        test_back_to_back();
        test_word("max_again", 8'd255, 0);
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
